// File: rtl/io_bank_pkg.sv
// Register map and bit positions shared by the io_bank RTL, MMU software and the bench.
package io_bank_pkg;
   localparam logic [7:0] IO_ID       = 8'h00;
   localparam logic [7:0] IO_GPIO_OUT = 8'h04;
   localparam logic [7:0] IO_GPIO_IN  = 8'h08;
   localparam logic [7:0] IO_TCOUNT   = 8'h0C;
   localparam logic [7:0] IO_TCMP     = 8'h10;
   localparam logic [7:0] IO_TCTRL    = 8'h14;
   localparam logic [7:0] IO_TXDATA   = 8'h18;
   localparam logic [7:0] IO_TXSTAT   = 8'h1C;

   // Word indices as seen on io_addr[7:2]
   localparam logic [5:0] W_ID       = IO_ID[7:2];
   localparam logic [5:0] W_GPIO_OUT = IO_GPIO_OUT[7:2];
   localparam logic [5:0] W_GPIO_IN  = IO_GPIO_IN[7:2];
   localparam logic [5:0] W_TCOUNT   = IO_TCOUNT[7:2];
   localparam logic [5:0] W_TCMP     = IO_TCMP[7:2];
   localparam logic [5:0] W_TCTRL    = IO_TCTRL[7:2];
   localparam logic [5:0] W_TXDATA   = IO_TXDATA[7:2];
   localparam logic [5:0] W_TXSTAT   = IO_TXSTAT[7:2];

   localparam int TCTRL_EN     = 0;
   localparam int TCTRL_IRQ_EN = 1;
   localparam int TCTRL_MATCH  = 2;

   localparam int TXSTAT_FULL  = 0;
   localparam int TXSTAT_EMPTY = 1;
   localparam int TXSTAT_OVF   = 2;
   localparam int TXSTAT_CNT   = 8;
endpackage

// File: rtl/io_bank_tx_fifo.sv
// Byte TX FIFO: registered storage, no fall-through; a push on a full FIFO is only taken alongside a pop.
module io_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int LOG   = 3
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LOG:0]     count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [LOG-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LOG:0]     count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (LOG+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + LOG'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + LOG'(1) : rd_ptr_q;
      count_d  = count_q + {{LOG{1'b0}}, do_push} - {{LOG{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; dout is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/io_bank.sv
// MMU I/O window responder: word register file with GPIO, 32-bit compare timer and a TX byte FIFO.
module io_bank
   import io_bank_pkg::*;
#(
   parameter logic [31:0] ID_VALUE = 32'h10B4_0001,
   parameter int          GPIO_W   = 8,
   parameter int          TX_DEPTH = 8,
   parameter int          TX_LOG   = 3
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic [7:0]        io_addr,
   input  logic              io_en,
   input  logic              io_we,
   input  logic [31:0]       io_data_write,
   output logic [31:0]       io_data_read,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);
   logic [5:0]        widx;
   logic              wr, rd;
   logic              wr_gpio, wr_tcount, wr_tcmp, wr_tctrl, wr_txstat, push, pop;
   logic [7:0]        push_byte;
   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d, sync1_q, sync2_q;
   logic [31:0]       tcount_q, tcount_d, tcmp_q, tcmp_d;
   logic              en_q, en_d, irq_en_q, irq_en_d, match_q, match_d, irq_q;
   logic              ovf_q, ovf_d;
   logic              tx_full, tx_empty;
   logic [TX_LOG:0]   tx_count;

   assign widx      = io_addr[7:2];
   assign wr        = io_en & io_we;
   assign rd        = io_en & ~io_we;
   assign wr_gpio   = wr & (widx == W_GPIO_OUT);
   assign wr_tcount = wr & (widx == W_TCOUNT);
   assign wr_tcmp   = wr & (widx == W_TCMP);
   assign wr_tctrl  = wr & (widx == W_TCTRL);
   assign wr_txstat = wr & (widx == W_TXSTAT);
   assign push      = wr & (widx == W_TXDATA);
   // Sub-word stores land on their own lane, so pick the byte the address points at
   assign push_byte = io_data_write[{io_addr[1:0], 3'b000} +: 8];
   assign pop       = tx_valid & tx_ready;

   io_tx_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH), .LOG(TX_LOG)) u_tx_fifo (
      .clk    (clk),
      .resetb (resetb),
      .push   (push),
      .din    (push_byte),
      .pop    (pop),
      .dout   (tx_data),
      .full   (tx_full),
      .empty  (tx_empty),
      .count  (tx_count)
   );

   assign tx_valid = ~tx_empty;
   assign gpio_out = gpio_out_q;
   assign irq      = irq_q;

   always_comb begin
      gpio_out_d = wr_gpio ? io_data_write[GPIO_W-1:0] : gpio_out_q;
      tcmp_d     = wr_tcmp ? io_data_write : tcmp_q;
      en_d       = wr_tctrl ? io_data_write[TCTRL_EN] : en_q;
      irq_en_d   = wr_tctrl ? io_data_write[TCTRL_IRQ_EN] : irq_en_q;
      tcount_d   = tcount_q;
      if (wr_tcount)  tcount_d = io_data_write;
      else if (en_q)  tcount_d = tcount_q + 32'd1;
      // Sticky flags: a new set event beats a same-cycle write-one-to-clear
      match_d = (en_q & (tcount_q == tcmp_q)) |
                (match_q & ~(wr_tctrl & io_data_write[TCTRL_MATCH]));
      ovf_d   = (push & tx_full & ~pop) |
                (ovf_q & ~(wr_txstat & io_data_write[TXSTAT_OVF]));
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         tcount_q   <= '0;
         tcmp_q     <= 32'hFFFF_FFFF;
         en_q       <= 1'b0;
         irq_en_q   <= 1'b0;
         match_q    <= 1'b0;
         irq_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         tcount_q   <= tcount_d;
         tcmp_q     <= tcmp_d;
         en_q       <= en_d;
         irq_en_q   <= irq_en_d;
         match_q    <= match_d;
         irq_q      <= match_d & irq_en_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      io_data_read = 32'h0;
      if (rd) begin
         case (widx)
            W_ID:       io_data_read = ID_VALUE;
            W_GPIO_OUT: io_data_read[GPIO_W-1:0] = gpio_out_q;
            W_GPIO_IN:  io_data_read[GPIO_W-1:0] = sync2_q;
            W_TCOUNT:   io_data_read = tcount_q;
            W_TCMP:     io_data_read = tcmp_q;
            W_TCTRL: begin
               io_data_read[TCTRL_EN]     = en_q;
               io_data_read[TCTRL_IRQ_EN] = irq_en_q;
               io_data_read[TCTRL_MATCH]  = match_q;
            end
            W_TXSTAT: begin
               io_data_read[TXSTAT_FULL]               = tx_full;
               io_data_read[TXSTAT_EMPTY]              = tx_empty;
               io_data_read[TXSTAT_OVF]                = ovf_q;
               io_data_read[TXSTAT_CNT +: TX_LOG + 1]  = tx_count;
            end
            default:    io_data_read = 32'h0;
         endcase
      end
   end
endmodule

// File: tb/tb_io_bank.sv
// Scoreboard bench for io_bank: stimulus pushes expected reads / FIFO bytes, a negedge monitor checks them.
module tb_io_bank;
   import io_bank_pkg::*;

   logic        clk = 1'b0;
   logic        resetb;
   logic [7:0]  io_addr;
   logic        io_en, io_we;
   logic [31:0] io_data_write, io_data_read;
   logic [7:0]  gpio_in, gpio_out;
   logic        irq;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;

   io_bank dut (
      .clk           (clk),
      .resetb        (resetb),
      .io_addr       (io_addr),
      .io_en         (io_en),
      .io_we         (io_we),
      .io_data_write (io_data_write),
      .io_data_read  (io_data_read),
      .gpio_in       (gpio_in),
      .gpio_out      (gpio_out),
      .irq           (irq),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: plain variables plus a byte queue for the FIFO
   logic [31:0] exp_rd[$];
   logic [7:0]  mq[$];
   logic [7:0]  m_gpio_out, m_gpio_in;
   logic [31:0] m_tcount, m_tcmp;
   logic [2:0]  m_tctrl;
   logic        m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_gpio_out = 8'h00;
      m_gpio_in  = 8'h00;
      m_tcount   = 32'h0;
      m_tcmp     = 32'hFFFF_FFFF;
      m_tctrl    = 3'b000;
      m_ovf      = 1'b0;
      mq.delete();
   endtask

   function automatic logic [31:0] exp_read(input logic [7:0] a);
      logic [31:0] r;
      int n;
      r = 32'h0;
      n = mq.size();
      case (a[7:2])
         W_ID:       r = 32'h10B4_0001;
         W_GPIO_OUT: r = {24'h0, m_gpio_out};
         W_GPIO_IN:  r = {24'h0, m_gpio_in};
         W_TCOUNT:   r = m_tcount;
         W_TCMP:     r = m_tcmp;
         W_TCTRL:    r = {29'h0, m_tctrl};
         W_TXSTAT: begin
            r[0]    = (n == 8);
            r[1]    = (n == 0);
            r[2]    = m_ovf;
            r[11:8] = 4'(n);
         end
         default:    r = 32'h0;
      endcase
      return r;
   endfunction

   // Applied at the commit edge, after any pop the monitor saw this cycle
   task automatic model_write(input logic [7:0] a, input logic [31:0] d);
      case (a[7:2])
         W_GPIO_OUT: m_gpio_out = d[7:0];
         W_TCOUNT:   m_tcount = d;
         W_TCMP:     m_tcmp = d;
         W_TCTRL:    m_tctrl = {m_tctrl[2] & ~d[2], d[1:0]};
         W_TXDATA: begin
            if (mq.size() < 8) mq.push_back(d[8*a[1:0] +: 8]);
            else m_ovf = 1'b1;
         end
         W_TXSTAT:   if (d[2]) m_ovf = 1'b0;
         default: ;
      endcase
   endtask

   task automatic cyc(input logic en, input logic we, input logic [7:0] a,
                      input logic [31:0] d, input logic rdy);
      io_en = en; io_we = we; io_addr = a; io_data_write = d; tx_ready = rdy;
      if (en && !we) exp_rd.push_back(exp_read(a));
      @(posedge clk);
      if (en && we) model_write(a, d);
      #1;
      io_en = 1'b0; io_we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      cyc(1'b1, 1'b0, a, 32'h0, 1'b0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      cyc(1'b1, 1'b1, a, d, 1'b0);
   endtask

   // Monitor: FIFO handshake and read responses, sampled mid-cycle
   always @(negedge clk) begin
      check("tx_valid", {31'h0, tx_valid}, {31'h0, mq.size() != 0});
      if (tx_valid && tx_ready && mq.size() > 0)
         check("tx_data", {24'h0, tx_data}, {24'h0, mq.pop_front()});
      if (io_en && !io_we) begin
         if (exp_rd.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got read at %h want none", io_addr);
         end else begin
            check($sformatf("rd@%02h", io_addr), io_data_read, exp_rd.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      resetb = 1'b0;
      io_addr = 8'h0; io_en = 1'b0; io_we = 1'b0; io_data_write = 32'h0;
      gpio_in = 8'h00; tx_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 resetb = 1'b1;

      // Reset state
      check("irq_rst", {31'h0, irq}, 32'h0);
      check("tx_valid_rst", {31'h0, tx_valid}, 32'h0);
      check("gpio_out_rst", {24'h0, gpio_out}, 32'h0);
      rd(IO_ID);
      rd(IO_TXSTAT);
      rd(IO_TCMP);
      rd(IO_TCTRL);
      rd(8'h40);

      // GPIO out and two-flop input path
      wr(IO_GPIO_OUT, 32'h0000_00A5);
      check("gpio_out_a5", {24'h0, gpio_out}, 32'hA5);
      gpio_in = 8'h3C;
      rd(IO_GPIO_IN);
      rd(IO_GPIO_IN);
      m_gpio_in = 8'h3C;
      rd(IO_GPIO_IN);
      rd(IO_GPIO_OUT);

      // Timer: match sets one edge after TCOUNT reaches TCMP
      t = $urandom_range(3, 10);
      wr(IO_TCMP, 32'(t));
      wr(IO_TCOUNT, 32'h0);
      wr(IO_TCTRL, 32'h3);
      repeat (t) @(posedge clk);
      #1 check("irq_early", {31'h0, irq}, 32'h0);
      @(posedge clk);
      #1 check("irq_set", {31'h0, irq}, 32'h1);
      wr(IO_TCTRL, 32'h6);
      check("irq_clr", {31'h0, irq}, 32'h0);
      m_tcount = 32'(t + 2);
      rd(IO_TCTRL);
      rd(IO_TCOUNT);
      repeat (3) cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
      rd(IO_TCOUNT);

      // FIFO: byte store on lane 2
      wr(8'h1A, 32'h0041_0000);
      check("tx_data_41", {24'h0, tx_data}, 32'h41);
      check("tx_valid_1", {31'h0, tx_valid}, 32'h1);
      rd(IO_TXSTAT);
      for (int i = 0; i < 8; i++) wr(IO_TXDATA | 8'(i % 4), $urandom);
      rd(IO_TXSTAT);
      check("ovf_set", {31'h0, m_ovf}, 32'h1);
      // Full: clear ovf, then push+pop in one cycle
      wr(IO_TXSTAT, 32'h4);
      cyc(1'b1, 1'b1, IO_TXDATA, 32'h0000_0077, 1'b1);
      rd(IO_TXSTAT);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b1);
      rd(IO_TXSTAT);

      // Reset during drain
      for (int i = 0; i < 4; i++) wr(IO_TXDATA, $urandom);
      cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b1);
      resetb = 1'b0;
      model_reset();
      #1;
      check("tx_valid_async", {31'h0, tx_valid}, 32'h0);
      check("tx_data_rst", {24'h0, tx_data}, 32'h0);
      @(posedge clk);
      #1 resetb = 1'b1;
      tx_ready = 1'b0;
      rd(IO_TXSTAT);
      rd(IO_TCMP);
      rd(IO_GPIO_OUT);
      m_gpio_in = gpio_in;
      rd(IO_GPIO_IN);

      // Random traffic against the model
      for (int i = 0; i < 500; i++) begin
         int op;
         logic rdy;
         logic [7:0] a;
         op  = $urandom_range(0, 9);
         rdy = ($urandom_range(0, 3) == 0);
         case (op)
            0, 1, 2, 3: cyc(1'b1, 1'b1, IO_TXDATA | 8'($urandom_range(0, 3)), $urandom, rdy);
            4, 5: begin
               a = 8'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
               cyc(1'b1, 1'b0, a, 32'h0, rdy);
            end
            6: begin
               cyc(1'b1, 1'b1, IO_GPIO_OUT, $urandom, rdy);
               check("gpio_out_rnd", {24'h0, gpio_out}, {24'h0, m_gpio_out});
            end
            7: cyc(1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? IO_TCMP : IO_TCOUNT, $urandom, rdy);
            8: cyc(1'b1, 1'b1, IO_TXSTAT, $urandom, rdy);
            default: cyc(1'b1, 1'b1, 8'(8'h20 + 4 * $urandom_range(0, 55)), $urandom, rdy);
         endcase
      end
      rd(IO_TXSTAT);
      rd(IO_TCOUNT);
      check("irq_quiet", {31'h0, irq}, 32'h0);
      check("rd_queue_drained", 32'(exp_rd.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
